fft_power_reorder: RTL and testbench

FFT_POWER_REORDER -- requirements
Module: fft_power_reorder

---
 rtl/fft_pkg.sv | 24 ++
 rtl/reorder_ram.sv | 22 ++
 rtl/fft_power_reorder.sv | 157 +++++++++++++++
 tb/tb_fft_power_reorder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sequencer state type and bit-reverse helper for the FFT power reorder block.
package fft_pkg;

  localparam int unsigned FFT_N     = 1024;
  localparam int unsigned FFT_LOG2N = 10;
  localparam int unsigned NUM_BINS  = FFT_N / 2 + 1;

  typedef enum logic [0:0] {
    StIdle,
    StRead
  } rd_state_e;

  // Reverses the low 'bits' bits of 'a'; bits above 'bits' come back as zero.
  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] a,
                                                  input int unsigned bits);
    logic [FFT_LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FFT_LOG2N; i++) begin
      if (i < bits) r[i] = a[bits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module reorder_ram #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 1024,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/fft_power_reorder.sv
// Reorders bit-reversed FFT output into natural order through ping-pong banks and emits
// re^2+im^2 for bins 0..N/2.
module fft_power_reorder
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 1024,
  localparam int unsigned LogN = $clog2(N)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               di_en,
  input  logic [WIDTH-1:0]   di_re,
  input  logic [WIDTH-1:0]   di_im,
  output logic               do_en,
  output logic [2*WIDTH-1:0] do_pw,
  output logic [LogN-1:0]    do_bin,
  output logic               do_last
);

  localparam logic [LogN-1:0] Half = LogN'(N / 2);

  // Write side
  logic [LogN-1:0] wr_cnt_q;
  logic            wr_bank_q;
  logic [LogN-1:0] wr_addr;
  logic            frame_done;

  assign frame_done = di_en && (wr_cnt_q == LogN'(N - 1));
  assign wr_addr    = LogN'(bitrev(FFT_LOG2N'(wr_cnt_q), LogN));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else if (di_en) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
      if (frame_done) wr_bank_q <= ~wr_bank_q;
    end
  end

  // Read sequencer; a hand-off parks in pend_q until the sequencer is idle
  rd_state_e       state_q, state_d;
  logic [LogN-1:0] rd_addr_q, rd_addr_d;
  logic            rd_bank_q;
  logic            pend_q, pend_bank_q;
  logic            start, rd_valid, rd_last;

  assign start = (state_q == StIdle) && pend_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      rd_bank_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      if (start) rd_bank_q <= pend_bank_q;
      if (frame_done) begin
        pend_q      <= 1'b1;
        pend_bank_q <= wr_bank_q;
      end else if (start) begin
        pend_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pend_q) state_d = StRead;
      StRead:  if (rd_addr_q == Half) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_valid  = (state_q == StRead);
    rd_last   = rd_valid && (rd_addr_q == Half);
    rd_addr_d = (rd_valid && !rd_last) ? rd_addr_q + 1'b1 : '0;
  end

  // Banks
  logic [2*WIDTH-1:0] bank_rdata [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_ram #(
      .Width(2 * WIDTH),
      .Depth(N)
    ) u_ram (
      .clock   (clock),
      .we_i    (di_en && (wr_bank_q == 1'(b))),
      .waddr_i (wr_addr),
      .wdata_i ({di_re, di_im}),
      .raddr_i (rd_addr_q),
      .rdata_o (bank_rdata[b])
    );
  end

  // Pipeline: RAM read -> squares -> sum
  logic                      v1_q, last1_q, bank1_q;
  logic [LogN-1:0]           bin1_q;
  logic [2*WIDTH-1:0]        rd_data;
  logic signed [WIDTH-1:0]   re1, im1;
  logic                      v2_q, last2_q;
  logic [LogN-1:0]           bin2_q;
  logic signed [2*WIDTH-1:0] sq_re_q, sq_im_q;
  logic                      do_en_q, do_last_q;
  logic [LogN-1:0]           do_bin_q;
  logic [2*WIDTH-1:0]        do_pw_q;

  assign rd_data = bank1_q ? bank_rdata[1] : bank_rdata[0];
  assign re1     = rd_data[2*WIDTH-1:WIDTH];
  assign im1     = rd_data[WIDTH-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      bank1_q   <= 1'b0;
      bin1_q    <= '0;
      v2_q      <= 1'b0;
      last2_q   <= 1'b0;
      bin2_q    <= '0;
      sq_re_q   <= '0;
      sq_im_q   <= '0;
      do_en_q   <= 1'b0;
      do_last_q <= 1'b0;
      do_bin_q  <= '0;
      do_pw_q   <= '0;
    end else begin
      v1_q    <= rd_valid;
      last1_q <= rd_last;
      bank1_q <= rd_bank_q;
      bin1_q  <= rd_addr_q;
      v2_q    <= v1_q;
      last2_q <= v1_q && last1_q;
      bin2_q  <= v1_q ? bin1_q : '0;
      // Full-precision: both operands sign-extend to 2*WIDTH before multiplying
      sq_re_q <= re1 * re1;
      sq_im_q <= im1 * im1;
      do_en_q   <= v2_q;
      do_last_q <= v2_q && last2_q;
      do_bin_q  <= v2_q ? bin2_q : '0;
      do_pw_q   <= v2_q ? ($unsigned(sq_re_q) + $unsigned(sq_im_q)) : '0;
    end
  end

  assign do_en   = do_en_q;
  assign do_pw   = do_pw_q;
  assign do_bin  = do_bin_q;
  assign do_last = do_last_q;

endmodule

// File: tb/tb_fft_power_reorder.sv
// Scoreboard bench for fft_power_reorder: driver queues expected bins, monitor checks outputs.
module tb_fft_power_reorder;

  localparam int N    = 1024;
  localparam int HALF = 512;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        di_en = 1'b0;
  logic [31:0] di_re = '0;
  logic [31:0] di_im = '0;
  logic        do_en;
  logic [63:0] do_pw;
  logic [9:0]  do_bin;
  logic        do_last;

  fft_power_reorder #(
    .WIDTH(32),
    .N(N)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .di_en   (di_en),
    .di_re   (di_re),
    .di_im   (di_im),
    .do_en   (do_en),
    .do_pw   (do_pw),
    .do_bin  (do_bin),
    .do_last (do_last)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [9:0]  bin;
    logic [63:0] pw;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   rise_q[$];
  int   cyc = 0;
  int   tb_cnt = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic signed [31:0] fre [N];
  logic signed [31:0] fim [N];

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 10; i++) if (k[i]) r = r | (1 << (9 - i));
    return r;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Cycle count plus an independent count of accepted samples, recording each frame end.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      tb_cnt <= 0;
    end else begin
      cyc <= cyc + 1;
      if (di_en) begin
        if (tb_cnt == N - 1) acc_q.push_back(cyc + 1);
        tb_cnt <= (tb_cnt == N - 1) ? 0 : tb_cnt + 1;
      end
    end
  end

  // Monitor
  initial begin
    bit   prev_en;
    int   run;
    int   acc;
    exp_t e;
    prev_en = 1'b0;
    run = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_en = 1'b0;
        run = 0;
      end else begin
        if (do_en) begin
          if (!prev_en) begin
            acc = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
            chk("latency", 80'(cyc - acc), 80'd4);
            rise_q.push_back(cyc);
          end
          run++;
          if (exp_q.size() == 0) begin
            chk("spurious bin", {69'd0, do_bin, 1'b1}, 80'd0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("bin %0d", e.bin), 80'({do_bin, do_pw, do_last}), 80'(e));
          end
        end else begin
          if (prev_en) chk("run length", 80'(run), 80'(HALF + 1));
          run = 0;
          chk("idle outputs zero", 80'({do_pw, do_bin, do_last}), 80'd0);
        end
        prev_en = do_en;
      end
    end
  end

  task automatic drive(input logic [31:0] re, input logic [31:0] im, input logic en);
    @(negedge clock);
    di_en = en;
    di_re = re;
    di_im = im;
  endtask

  task automatic push_expected();
    logic signed [63:0] r, i;
    logic signed [63:0] rr, ii;
    exp_t e;
    int s;
    for (int b = 0; b <= HALF; b++) begin
      s  = brev(b);
      r  = 64'(fre[s]);
      i  = 64'(fim[s]);
      rr = r * r;
      ii = i * i;
      e.bin  = 10'(b);
      e.pw   = $unsigned(rr) + $unsigned(ii);
      e.last = (b == HALF);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input int gap_pct);
    for (int k = 0; k < N; k++) begin
      if (gap_pct > 0) while (int'($urandom_range(99)) < gap_pct) drive('0, '0, 1'b0);
      drive(fre[k], fim[k], 1'b1);
    end
    push_expected();
  endtask

  task automatic drain();
    int t;
    drive('0, '0, 1'b0);
    t = 0;
    while ((exp_q.size() != 0 || do_en) && t < 4000) begin
      @(negedge clock);
      t++;
    end
    repeat (3) @(negedge clock);
    chk("drain leftover bins", 80'(exp_q.size()), 80'd0);
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset outputs", 80'({do_en, do_pw, do_bin, do_last}), 80'd0);
    @(negedge clock);
    chk("reset outputs held", 80'({do_en, do_pw, do_bin, do_last}), 80'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Ramp: re = count, im = 0
    for (int k = 0; k < N; k++) begin
      fre[k] = 32'(k);
      fim[k] = '0;
    end
    send_frame(0);
    drain();

    // Most negative values on both components
    for (int k = 0; k < N; k++) begin
      fre[k] = 32'h8000_0000;
      fim[k] = 32'h8000_0000;
    end
    send_frame(0);
    drain();

    // Three frames with roughly half the cycles idle
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        fre[k] = $urandom;
        fim[k] = $urandom;
      end
      send_frame(50);
      repeat (f) drive('0, '0, 1'b0);
    end
    drain();

    // Two back-to-back frames at full rate
    rise_q.delete();
    for (int k = 0; k < N; k++) begin
      fre[k] = 32'(3 * k - 1000);
      fim[k] = 32'(-k);
    end
    send_frame(0);
    for (int k = 0; k < N; k++) begin
      fre[k] = 32'(k * k);
      fim[k] = 32'(7 - 5 * k);
    end
    send_frame(0);
    drain();
    chk("b2b frame count", 80'(rise_q.size()), 80'd2);
    if (rise_q.size() == 2) chk("b2b bin0 spacing", 80'(rise_q[1] - rise_q[0]), 80'd1024);

    // Reset after 600 samples, then a full frame
    for (int k = 0; k < N; k++) begin
      fre[k] = 32'(-7 * k);
      fim[k] = 32'(k + 11);
    end
    for (int k = 0; k < 600; k++) drive(32'hdead_0000 + 32'(k), 32'(k), 1'b1);
    @(negedge clock);
    reset = 1'b0;
    di_en = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid-frame reset outputs", 80'({do_en, do_pw, do_bin, do_last}), 80'd0);
    reset = 1'b1;
    send_frame(0);
    drain();
    chk("unmatched frame ends", 80'(acc_q.size()), 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
